// File: rtl/pix_wr_ctrl.sv
// Raster-order pixel stream to square-image memory write controller.
// Latency: accepted pixel -> wr_en/wr_addr/wr_data one cycle later; frame_done rides the last write.
// Backpressure: s_ready high only in WRITE, so the source may stall any number of cycles.
//
// Ports:
//   clk, rst_n (async, active-high), sclr (sync clear)
//   start, img_dim      : frame request and side length (1..256), latched in IDLE
//   s_valid/s_ready/s_data : pixel stream handshake
//   wr_en/wr_addr/wr_data  : registered memory write port
//   x_cnt/y_cnt         : position of the next pixel to accept
//   busy, frame_done    : frame in progress, one-cycle end-of-frame pulse
module pix_wr_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17,
  parameter int DIM_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclr,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_dim,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [7:0]        x_cnt,
  output logic [7:0]        y_cnt,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state;
  logic [7:0]        dim_m1;    // latched side length minus one; 256 fits in 8 bits this way
  logic [ADDR_W-1:0] addr_acc;  // rows are contiguous, so the address just counts pixels
  logic              dim_ok;
  logic              x_last;
  logic              y_last;

  assign dim_ok  = (img_dim != '0) && (img_dim <= DIM_W'(256));
  assign x_last  = (x_cnt == dim_m1);
  assign y_last  = (y_cnt == dim_m1);
  assign s_ready = (state == WRITE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      dim_m1     <= '0;
      addr_acc   <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else if (sclr) begin
      // A pixel handshaken in this cycle is dropped on purpose.
      state      <= IDLE;
      addr_acc   <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && dim_ok) begin
            dim_m1   <= 8'(img_dim - DIM_W'(1));
            addr_acc <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (s_valid) begin
            wr_en    <= 1'b1;
            wr_addr  <= addr_acc;
            wr_data  <= s_data;
            addr_acc <= addr_acc + ADDR_W'(1);
            if (x_last) begin
              if (y_last) begin
                // Last pixel: x/y stay parked at dim-1 for the reader.
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 8'(1);
              end
            end else begin
              x_cnt <= x_cnt + 8'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pix_wr_ctrl.sv
module tb_pix_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclr = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  img_dim = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  x_cnt;
  logic [7:0]  y_cnt;
  logic        busy;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  pix_wr_ctrl #(.DATA_W(8), .ADDR_W(17), .DIM_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .start(start), .img_dim(img_dim),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a frame is a count of accepted pixels; position and address follow from it.
  int m_phase = 0;   // 0 idle, 1 accepting, 2 finished
  int m_dim   = 1;
  int m_cnt   = 0;
  int m_wr_en = 0;
  int m_addr  = 0;
  int m_data  = 0;
  int m_fd    = 0;

  function automatic int exp_x();
    if (m_cnt == m_dim * m_dim) return m_dim - 1;
    return m_cnt % m_dim;
  endfunction

  function automatic int exp_y();
    if (m_cnt == m_dim * m_dim) return m_dim - 1;
    return m_cnt / m_dim;
  endfunction

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_phase <= 0; m_dim <= 1; m_cnt <= 0; m_wr_en <= 0; m_addr <= 0; m_data <= 0; m_fd <= 0;
    end else if (sclr) begin
      m_phase <= 0; m_cnt <= 0; m_wr_en <= 0; m_fd <= 0;
    end else begin
      m_wr_en <= 0;
      m_fd    <= 0;
      if (m_phase == 0) begin
        if (start && img_dim >= 1 && img_dim <= 256) begin
          m_dim <= int'(img_dim); m_cnt <= 0; m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        if (s_valid) begin
          m_wr_en <= 1;
          m_addr  <= exp_y() * m_dim + exp_x();
          m_data  <= int'(s_data);
          m_cnt   <= m_cnt + 1;
          if (m_cnt + 1 == m_dim * m_dim) begin
            m_phase <= 2; m_fd <= 1;
          end
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("s_ready", s_ready, m_phase == 1);
    chk("busy", busy, m_phase != 0);
    chk("wr_en", wr_en, m_wr_en);
    chk("frame_done", frame_done, m_fd);
    chk("x_cnt", x_cnt, exp_x());
    chk("y_cnt", y_cnt, exp_y());
    if (m_wr_en != 0) begin
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, m_data);
    end
  end

  // Independent log of what the DUT wrote, for literal end-of-test expectations.
  int addr_log[$];
  int fd_cnt  = 0;
  int fd_addr = -1;
  always @(negedge clk) begin
    if (wr_en) addr_log.push_back(int'(wr_addr));
    if (frame_done) begin
      fd_cnt++;
      fd_addr = int'(wr_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int dim);
    start = 1'b1;
    img_dim = 9'(dim);
    step();
    start = 1'b0;
  endtask

  // Feed one frame; pct is the chance (percent) that s_valid is high in a cycle.
  task automatic feed_frame(input int dim, input int pct, input int budget);
    int c;
    c = 0;
    while (m_cnt < dim * dim && c < budget) begin
      s_valid = ($urandom_range(99) < pct);
      s_data  = 8'($urandom);
      step();
      c++;
    end
    s_valid = 1'b0;
    if (c >= budget) chk("frame_timeout", m_cnt, dim * dim);
  endtask

  initial begin
    int base;
    int fd_base;

    #1 rst_n = 1'b1;
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_x", x_cnt, 0);
    chk("rst_y", y_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    step();
    step();
    rst_n = 1'b0;
    step();

    // dim 16, full throughput
    base = addr_log.size(); fd_base = fd_cnt;
    pulse_start(16);
    feed_frame(16, 100, 300);
    step(); step();
    chk("t1_writes", addr_log.size() - base, 256);
    chk("t1_frame_done_cnt", fd_cnt - fd_base, 1);
    chk("t1_frame_done_addr", fd_addr, 255);
    if (addr_log.size() > base) chk("t1_first_addr", addr_log[base], 0);
    chk("t1_busy_after", busy, 0);

    // dim 4, random stalls
    base = addr_log.size(); fd_base = fd_cnt;
    pulse_start(4);
    feed_frame(4, 50, 400);
    step(); step();
    chk("t2_writes", addr_log.size() - base, 16);
    chk("t2_x_final", x_cnt, 3);
    chk("t2_y_final", y_cnt, 3);
    chk("t2_frame_done_cnt", fd_cnt - fd_base, 1);

    // illegal dims are ignored, then dim 1
    base = addr_log.size(); fd_base = fd_cnt;
    s_valid = 1'b1;
    pulse_start(0);
    chk("t3_dim0_ready", s_ready, 0);
    pulse_start(300);
    chk("t3_dim300_ready", s_ready, 0);
    step();
    s_valid = 1'b0;
    chk("t3_bad_writes", addr_log.size() - base, 0);
    chk("t3_bad_busy", busy, 0);
    pulse_start(1);
    feed_frame(1, 100, 10);
    step(); step();
    chk("t3_dim1_writes", addr_log.size() - base, 1);
    chk("t3_dim1_fd_cnt", fd_cnt - fd_base, 1);
    chk("t3_dim1_fd_addr", fd_addr, 0);

    // sclr after 100 transfers, with a transfer in the same cycle
    pulse_start(16);
    base = addr_log.size();
    s_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = 8'(i);
      step();
    end
    sclr = 1'b1;
    s_data = 8'hAA;
    step();
    sclr = 1'b0;
    s_valid = 1'b0;
    chk("t4_wr_en_after_sclr", wr_en, 0);
    chk("t4_x_after_sclr", x_cnt, 0);
    chk("t4_y_after_sclr", y_cnt, 0);
    chk("t4_busy_after_sclr", busy, 0);
    step();
    chk("t4_writes_before_sclr", addr_log.size() - base, 100);
    base = addr_log.size();
    pulse_start(16);
    feed_frame(16, 100, 300);
    step(); step();
    chk("t4_restart_writes", addr_log.size() - base, 256);
    if (addr_log.size() > base) chk("t4_restart_first_addr", addr_log[base], 0);

    // asynchronous reset mid-frame
    pulse_start(8);
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    #2 rst_n = 1'b1;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_s_ready", s_ready, 0);
    chk("t5_async_wr_en", wr_en, 0);
    chk("t5_async_wr_addr", wr_addr, 0);
    chk("t5_async_x", x_cnt, 0);
    chk("t5_async_y", y_cnt, 0);
    step(); step();
    rst_n = 1'b0;
    base = addr_log.size(); fd_base = fd_cnt;
    for (int i = 0; i < 5; i++) step();
    s_valid = 1'b0;
    chk("t5_idle_writes", addr_log.size() - base, 0);
    chk("t5_idle_fd", fd_cnt - fd_base, 0);
    chk("t5_idle_busy", busy, 0);

    // dim 256, full throughput
    base = addr_log.size(); fd_base = fd_cnt;
    pulse_start(256);
    feed_frame(256, 100, 66000);
    chk("t6_x_max", x_cnt, 255);
    chk("t6_y_max", y_cnt, 255);
    step(); step();
    chk("t6_writes", addr_log.size() - base, 65536);
    chk("t6_frame_done_cnt", fd_cnt - fd_base, 1);
    chk("t6_last_addr", fd_addr, 65535);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
